// File: rtl/fetch_stage_if.sv
// Instruction-memory read bus between the fetch stage (master) and
// instruction memory (slave). A transfer completes in any cycle where
// imem_req and imem_ack are both high; imem_rdata is valid in that cycle.
interface fetch_stage_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 16-bit pipelined RISC core.
// Owns the PC, issues word reads over the imem req/ack bus, splits the
// selected word into IF/ID fields and drives the IF/ID write enable.
// Stalls, redirects and flush bubbles are resolved here.
//
// Optional build macro: FETCH_PERF_CNT_EN adds saturating fetch_count and
// bubble_count outputs. Without it neither ports nor counters exist.
//
// state   | meaning
// --------+---------------------------------------------------------------
// REQ     | request to PC outstanding; deliver on ack, bubble otherwise
// HOLD    | word acked during a stall, parked in hold buffer, no request
// DISCARD | request to a stale (pre-redirect) address still in flight;
//         | its data is dropped when the ack arrives
module fetch_stage #(
    parameter logic [15:0] RESET_PC         = 16'h0000,
    parameter int          OPCODE_WIDTH     = 4,
    parameter int          REG_WIDTH        = 3,
    parameter int          I_IMM_WIDTH      = 5,
    parameter int          S_IMM_WIDTH      = 9,
    parameter int          JMP_OFFSET_WIDTH = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic                        redirect_valid,
    input  logic [15:0]                 redirect_pc,
    fetch_stage_if.master               imem,
    output logic                        ifid_wr,
    output logic [OPCODE_WIDTH-1:0]     opcode_out,
    output logic [REG_WIDTH-1:0]        rd_out,
    output logic [REG_WIDTH-1:0]        rs1_out,
    output logic [REG_WIDTH-1:0]        rs2_out,
    output logic [I_IMM_WIDTH-1:0]      I_immediate_out,
    output logic [S_IMM_WIDTH-1:0]      S_immediate_out,
    output logic [JMP_OFFSET_WIDTH-1:0] jmp_offset_out,
    output logic                        mode_out,
    output logic [15:0]                 pc_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]                 fetch_count,
    output logic [15:0]                 bubble_count
`endif
);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    // Which word is presented to the IF/ID register this cycle.
    typedef enum logic [1:0] {
        SEL_NOP  = 2'd0,
        SEL_LIVE = 2'd1,
        SEL_HOLD = 2'd2
    } sel_t;

    state_t      state, state_next;
    sel_t        sel;
    logic [15:0] pc, pc_next;
    logic [15:0] hold_instr, hold_instr_next;
    logic [15:0] hold_pc, hold_pc_next;
    logic [15:0] disc_addr, disc_addr_next;
    logic [15:0] word;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    // PC, hold buffer and stale-request address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            hold_instr <= 16'h0000;
            hold_pc    <= 16'h0000;
            disc_addr  <= 16'h0000;
        end else begin
            pc         <= pc_next;
            hold_instr <= hold_instr_next;
            hold_pc    <= hold_pc_next;
            disc_addr  <= disc_addr_next;
        end
    end

    // Next-state and next-PC selection; redirect outranks stall everywhere.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        hold_instr_next = hold_instr;
        hold_pc_next    = hold_pc;
        disc_addr_next  = disc_addr;
        case (state)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_next         = redirect_pc;
                    hold_instr_next = 16'h0000;
                    hold_pc_next    = 16'h0000;
                    if (!imem.imem_ack) begin
                        // The unacked request keeps its address on the bus.
                        state_next     = S_DISCARD;
                        disc_addr_next = pc;
                    end
                end else if (imem.imem_ack) begin
                    if (!stall) begin
                        pc_next = pc + 16'd1;
                    end else begin
                        hold_instr_next = imem.imem_rdata;
                        hold_pc_next    = pc;
                        state_next      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_next         = redirect_pc;
                    hold_instr_next = 16'h0000;
                    hold_pc_next    = 16'h0000;
                    state_next      = S_REQ;
                end else if (!stall) begin
                    pc_next    = hold_pc + 16'd1;
                    state_next = S_REQ;
                end
            end
            S_DISCARD: begin
                if (redirect_valid) begin
                    pc_next         = redirect_pc;
                    hold_instr_next = 16'h0000;
                    hold_pc_next    = 16'h0000;
                end
                // Once the stale transfer completes nothing is outstanding.
                if (imem.imem_ack) begin
                    state_next = S_REQ;
                end
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
    end

    // Bus request and IF/ID write/selection; everything is quiet in reset.
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc;
        ifid_wr        = 1'b0;
        sel            = SEL_NOP;
        if (!rst) begin
            case (state)
                S_REQ: begin
                    imem.imem_req = 1'b1;
                    if (redirect_valid) begin
                        ifid_wr = 1'b1;
                    end else if (!stall) begin
                        ifid_wr = 1'b1;
                        if (imem.imem_ack) begin
                            sel = SEL_LIVE;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        ifid_wr = 1'b1;
                    end else if (!stall) begin
                        ifid_wr = 1'b1;
                        sel     = SEL_HOLD;
                    end
                end
                S_DISCARD: begin
                    imem.imem_req  = 1'b1;
                    imem.imem_addr = disc_addr;
                    ifid_wr        = redirect_valid | ~stall;
                end
                default: begin
                    ifid_wr = 1'b0;
                end
            endcase
        end
    end

    // Word mux and field split in the layout the IF/ID register expects.
    always_comb begin
        word            = 16'h0000;
        pc_out          = 16'h0000;
        rd_out          = '0;
        rs1_out         = '0;
        rs2_out         = '0;
        I_immediate_out = '0;
        S_immediate_out = '0;
        jmp_offset_out  = '0;
        mode_out        = 1'b0;
        case (sel)
            SEL_LIVE: begin
                word   = imem.imem_rdata;
                pc_out = pc;
            end
            SEL_HOLD: begin
                word   = hold_instr;
                pc_out = hold_pc;
            end
            default: begin
                word   = 16'h0000;
                pc_out = 16'h0000;
            end
        endcase
        opcode_out = word[15:12];
        if (word[15:12] <= 4'd2) begin
            rd_out  = word[11:9];
            rs1_out = word[8:6];
            rs2_out = word[5:3];
        end else if (word[15:12] <= 4'd8) begin
            mode_out        = word[11];
            rd_out          = word[10:8];
            rs1_out         = word[7:5];
            I_immediate_out = word[4:0];
        end else if (word[15:12] <= 4'd11) begin
            jmp_offset_out = word[11:0];
        end else begin
            rs1_out         = word[11:9];
            S_immediate_out = word[8:0];
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating counts of real instructions and NOP words written to IF/ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count  <= 16'h0000;
            bubble_count <= 16'h0000;
        end else if (ifid_wr) begin
            if (sel != SEL_NOP) begin
                if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
            end else begin
                if (bubble_count != 16'hFFFF) bubble_count <= bubble_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized stimulus checked every cycle against a
// behavioural model of the fetch rules.
module tb_fetch_stage;

    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [4:0]  iimm;
        logic [8:0]  simm;
        logic [11:0] joff;
        logic        mode;
    } fields_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        ifid_wr;
    logic [3:0]  opcode_out;
    logic [2:0]  rd_out, rs1_out, rs2_out;
    logic [4:0]  I_immediate_out;
    logic [8:0]  S_immediate_out;
    logic [11:0] jmp_offset_out;
    logic        mode_out;
    logic [15:0] pc_out;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count, bubble_count;
`endif

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(16'h0010)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem            (bus),
        .ifid_wr         (ifid_wr),
        .opcode_out      (opcode_out),
        .rd_out          (rd_out),
        .rs1_out         (rs1_out),
        .rs2_out         (rs2_out),
        .I_immediate_out (I_immediate_out),
        .S_immediate_out (S_immediate_out),
        .jmp_offset_out  (jmp_offset_out),
        .mode_out        (mode_out),
        .pc_out          (pc_out)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count     (fetch_count),
        .bubble_count    (bubble_count)
`endif
    );

    fields_t act_f;
    assign act_f = {opcode_out, rd_out, rs1_out, rs2_out, I_immediate_out,
                    S_immediate_out, jmp_offset_out, mode_out};

    int n_cmp = 0;
    int n_bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Field layout by instruction class, straight from the opcode ranges.
    function automatic fields_t decode(input logic [15:0] w);
        fields_t f;
        int op;
        f  = '0;
        op = int'(w[15:12]);
        f.op = 4'(op);
        if (op <= 2) begin
            f.rd  = 3'((w >> 9) & 16'd7);
            f.rs1 = 3'((w >> 6) & 16'd7);
            f.rs2 = 3'((w >> 3) & 16'd7);
        end else if (op <= 8) begin
            f.mode = 1'((w >> 11) & 16'd1);
            f.rd   = 3'((w >> 8) & 16'd7);
            f.rs1  = 3'((w >> 5) & 16'd7);
            f.iimm = 5'(w & 16'd31);
        end else if (op <= 11) begin
            f.joff = 12'(w & 16'h0FFF);
        end else begin
            f.rs1  = 3'((w >> 9) & 16'd7);
            f.simm = 9'(w & 16'h01FF);
        end
        return f;
    endfunction

    // Behavioural model: PC, an optional parked word, and an optional stale
    // request whose data must be thrown away.
    logic [15:0] m_pc        = 16'h0010;
    logic        m_held      = 1'b0;
    logic [15:0] m_hold_word = 16'h0000;
    logic [15:0] m_hold_pc   = 16'h0000;
    logic        m_discard   = 1'b0;
    logic [15:0] m_disc_addr = 16'h0000;
    int unsigned m_fetch     = 0;
    int unsigned m_bubble    = 0;
    logic        e_req, e_wr, e_real;
    logic [15:0] e_addr, e_word, e_pc_out;

    // Compare process: checks DUT outputs against the model once per cycle,
    // then advances the model with the inputs of that cycle.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_imem_req", 64'(bus.imem_req), 64'd0);
            chk("rst_ifid_wr", 64'(ifid_wr), 64'd0);
            chk("rst_pc_out", 64'(pc_out), 64'd0);
            chk("rst_fields", 64'(act_f), 64'd0);
            m_pc = 16'h0010; m_held = 1'b0; m_discard = 1'b0;
            m_hold_word = 16'h0000; m_hold_pc = 16'h0000;
            m_fetch = 0; m_bubble = 0;
        end else begin
            e_req    = !m_held;
            e_addr   = m_discard ? m_disc_addr : m_pc;
            e_wr     = 1'b0;
            e_real   = 1'b0;
            e_word   = 16'h0000;
            e_pc_out = 16'h0000;
            if (redirect_valid) begin
                e_wr = 1'b1;
                if (e_req && !bus.imem_ack) begin
                    if (!m_discard) m_disc_addr = m_pc;
                    m_discard = 1'b1;
                end else begin
                    m_discard = 1'b0;
                end
                m_pc   = redirect_pc;
                m_held = 1'b0;
            end else if (m_held) begin
                if (!stall) begin
                    e_wr = 1'b1; e_real = 1'b1;
                    e_word = m_hold_word; e_pc_out = m_hold_pc;
                    m_pc = m_hold_pc + 16'd1;
                    m_held = 1'b0;
                end
            end else if (m_discard) begin
                e_wr = !stall;
                if (bus.imem_ack) m_discard = 1'b0;
            end else if (bus.imem_ack) begin
                if (!stall) begin
                    e_wr = 1'b1; e_real = 1'b1;
                    e_word = bus.imem_rdata; e_pc_out = m_pc;
                    m_pc = m_pc + 16'd1;
                end else begin
                    m_held = 1'b1; m_hold_word = bus.imem_rdata; m_hold_pc = m_pc;
                end
            end else begin
                e_wr = !stall;
            end

            chk("imem_req", 64'(bus.imem_req), 64'(e_req));
            if (e_req) chk("imem_addr", 64'(bus.imem_addr), 64'(e_addr));
            chk("ifid_wr", 64'(ifid_wr), 64'(e_wr));
            if (e_wr) begin
                chk("pc_out", 64'(pc_out), 64'(e_pc_out));
                chk("fields", 64'(act_f), 64'(decode(e_word)));
            end
`ifdef FETCH_PERF_CNT_EN
            chk("fetch_count", 64'(fetch_count), 64'(m_fetch));
            chk("bubble_count", 64'(bubble_count), 64'(m_bubble));
`endif
            if (e_wr && e_real && m_fetch < 65535) m_fetch++;
            if (e_wr && !e_real && m_bubble < 65535) m_bubble++;
        end
    end

    // One cycle of stimulus, applied just after the rising edge; returns
    // with outputs settled so literal checks can follow.
    task automatic step(input logic r, input logic st, input logic rv,
                        input logic [15:0] rp, input logic ak, input logic [15:0] rd);
        @(posedge clk);
        #1;
        rst = r; stall = st; redirect_valid = rv; redirect_pc = rp;
        bus.imem_ack = ak; bus.imem_rdata = rd;
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
        bus.imem_ack = 1'b0; bus.imem_rdata = 16'h0000;

        step(1, 0, 0, 16'h0, 1, 16'h1234);
        step(1, 0, 0, 16'h0, 1, 16'h1234);
        chk("reset_req", 64'(bus.imem_req), 64'd0);
        chk("reset_wr", 64'(ifid_wr), 64'd0);

        // Back-to-back acked fetches from RESET_PC.
        step(0, 0, 0, 16'h0, 1, 16'h1A5B);
        chk("t1_addr0", 64'(bus.imem_addr), 64'h10);
        chk("t1_pc0", 64'(pc_out), 64'h10);
        chk("t1_r_fields", 64'({opcode_out, rd_out, rs1_out, rs2_out}), 64'({4'd1, 3'd5, 3'd1, 3'd3}));
        step(0, 0, 0, 16'h0, 1, 16'h3C8E);
        chk("t1_pc1", 64'(pc_out), 64'h11);
        chk("t1_i_fields", 64'({mode_out, rd_out, rs1_out, I_immediate_out}), 64'({1'b1, 3'd4, 3'd4, 5'd14}));
        step(0, 0, 0, 16'h0, 1, 16'hA123);
        chk("t1_pc2", 64'(pc_out), 64'h12);
        chk("t1_j_offset", 64'(jmp_offset_out), 64'h123);

        // Ack delayed: two bubbles then the word, address held throughout.
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 16'h0, 0, 16'hFFFF);
            chk("t2_bubble_wr", 64'(ifid_wr), 64'd1);
            chk("t2_bubble_op", 64'(opcode_out), 64'd0);
            chk("t2_bubble_pc", 64'(pc_out), 64'd0);
            chk("t2_addr", 64'(bus.imem_addr), 64'h13);
        end
        step(0, 0, 0, 16'h0, 1, 16'h5123);
        chk("t2_addr_ack", 64'(bus.imem_addr), 64'h13);
        chk("t2_pc", 64'(pc_out), 64'h13);
        chk("t2_op", 64'(opcode_out), 64'd5);
        step(0, 0, 0, 16'h0, 1, 16'h1111);
        chk("t2_pc_next", 64'(pc_out), 64'h14);

        // Stall for 4 cycles with the ack in the first one.
        step(0, 1, 0, 16'h0, 1, 16'hC1FF);
        chk("t3_wr_ack", 64'(ifid_wr), 64'd0);
        chk("t3_req_ack", 64'(bus.imem_req), 64'd1);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch5", 64'(fetch_count), 64'd5);
        chk("perf_bubble2", 64'(bubble_count), 64'd2);
`endif
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 16'h0, 0, 16'h0);
            chk("t3_req_held", 64'(bus.imem_req), 64'd0);
            chk("t3_wr_held", 64'(ifid_wr), 64'd0);
        end
        step(0, 0, 0, 16'h0, 0, 16'h0);
        chk("t3_deliver_wr", 64'(ifid_wr), 64'd1);
        chk("t3_deliver_pc", 64'(pc_out), 64'h15);
        chk("t3_s_fields", 64'({opcode_out, rs1_out, S_immediate_out}), 64'({4'hC, 3'd0, 9'h1FF}));
        step(0, 0, 0, 16'h0, 0, 16'h0);
        chk("t3_next_addr", 64'(bus.imem_addr), 64'h16);

        // Redirect with an outstanding unacked request to 0x0012.
        step(0, 0, 1, 16'h0012, 1, 16'h7777);
        step(0, 0, 0, 16'h0, 0, 16'h0);
        chk("t4_outstanding", 64'(bus.imem_addr), 64'h12);
        step(0, 0, 1, 16'h0040, 0, 16'h0);
        chk("t4_flush_wr", 64'(ifid_wr), 64'd1);
        chk("t4_flush_op", 64'(opcode_out), 64'd0);
        step(0, 0, 0, 16'h0, 0, 16'h0);
        chk("t4_stale_addr", 64'(bus.imem_addr), 64'h12);
        step(0, 0, 0, 16'h0, 1, 16'h3FFF);
        chk("t4_drop_op", 64'(opcode_out), 64'd0);
        chk("t4_drop_pc", 64'(pc_out), 64'd0);
        step(0, 0, 0, 16'h0, 1, 16'h2000);
        chk("t4_new_addr", 64'(bus.imem_addr), 64'h40);
        chk("t4_new_pc", 64'(pc_out), 64'h40);

        // PC wrap and reset mid-request.
        step(0, 0, 1, 16'hFFFF, 1, 16'h0);
        step(0, 0, 0, 16'h0, 1, 16'h9FFF);
        chk("t5_pc_ffff", 64'(pc_out), 64'hFFFF);
        step(0, 0, 0, 16'h0, 0, 16'h0);
        chk("t5_wrap_addr", 64'(bus.imem_addr), 64'h0000);
        step(1, 0, 0, 16'h0, 0, 16'h0);
        chk("t5_rst_req", 64'(bus.imem_req), 64'd0);
        step(0, 0, 0, 16'h0, 0, 16'h0);
        chk("t5_restart_req", 64'(bus.imem_req), 64'd1);
        chk("t5_restart_addr", 64'(bus.imem_addr), 64'h10);

        // Randomized traffic, checked by the compare process.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] rp;
            rp = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom);
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0), rp, ($urandom_range(0, 1) == 1), 16'($urandom));
        end

`ifdef FETCH_PERF_CNT_EN
        // Drive enough deliveries to hit the saturation point.
        for (int i = 0; i < 65600; i++) begin
            step(0, 0, 0, 16'h0, 1, 16'($urandom));
        end
        step(0, 0, 0, 16'h0, 1, 16'h1000);
        chk("perf_saturate", 64'(fetch_count), 64'hFFFF);
`endif

        step(0, 0, 0, 16'h0, 0, 16'h0);
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 16-bit pipelined RISC core, sitting directly upstream of the IF/ID pipeline register. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and splits each fetched word into opcode/register/immediate/offset fields in the layout the IF/ID register consumes. It also drives that register's write enable. Stalls, control-flow redirects and flush bubbles are handled here, so the register itself stays a plain enable-gated latch.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- OPCODE_WIDTH, 4; REG_WIDTH, 3; I_IMM_WIDTH, 5; S_IMM_WIDTH, 9; JMP_OFFSET_WIDTH, 12: field widths; they must sum into a 16-bit word as laid out below
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hazard unit: hold IF/ID contents and PC
- redirect_valid  in  1  taken branch/jump/call/return this cycle
- redirect_pc  in  16  target PC, sampled when redirect_valid=1
- imem_req  out  1  read request; held high until accepted
- imem_addr  out  16  word address (= PC) of the request
- imem_ack  in  1  transfer completes when imem_req && imem_ack
- imem_rdata  in  16  instruction word, valid in the ack cycle
- ifid_wr  out  1  write enable to the IF/ID register
- opcode_out, rd_out, rs1_out, rs2_out, I_immediate_out, S_immediate_out, jmp_offset_out, mode_out  out  field widths  split instruction
- pc_out  out  16  PC of the delivered instruction; 0 for bubbles

## Operation
- Field split is combinational from the selected word W (live imem_rdata, the hold buffer, or the NOP word 16'h0000). opcode = W[15:12] always. Any field not belonging to the format is 0.
- R class, opcode 0–2: rd = W[11:9], rs1 = W[8:6], rs2 = W[5:3].
- I class, opcode 3–8: mode = W[11], rd = W[10:8], rs1 = W[7:5], I_imm = W[4:0].
- J class, opcode 9–11: jmp_offset = W[11:0].
- S class, opcode 12–15: rs1 = W[11:9], S_imm = W[8:0].
- State machine states: REQ, HOLD, DISCARD.
  - REQ: imem_req = 1 and imem_addr = PC.
    - On ack with stall=0: deliver imem_rdata (ifid_wr = 1, pc_out = PC); PC <= PC+1; stay in REQ.
    - On ack with stall=1: capture the word into hold_instr/hold_pc; go to HOLD.
    - No ack with stall=0: deliver a bubble (ifid_wr = 1, NOP word).
    - stall=1 with no ack: ifid_wr = 0.
  - HOLD: imem_req = 0. When stall falls, deliver the held word with pc_out = hold_pc, set PC <= hold_pc+1, go to REQ.
  - DISCARD: imem_req = 1 with imem_addr = the latched old address. The acked data is dropped and the state returns to REQ. Until the ack arrives, bubbles go out whenever stall=0.
- Redirect has the highest priority, above stall:
  - In the redirect cycle, drive ifid_wr = 1 with the NOP word (flushes IF/ID) and set PC <= redirect_pc.
  - The hold buffer is dropped.
  - If a request is outstanding and not acked in that cycle, go to DISCARD. Otherwise go to REQ.
- Redirect while already in DISCARD: update PC and stay in DISCARD.
- PC arithmetic is 16-bit modulo; 16'hFFFF+1 = 16'h0000.

## Timing
- Reset values:
  - PC = RESET_PC, state = REQ, hold buffer = 0.
  - imem_req is forced 0 while rst=1.
  - ifid_wr = 0 and all field outputs and pc_out are 0 while rst=1.
- The first request is issued in the first cycle after rst deasserts.
- Zero-latency path: an ack in cycle t with stall=0 gives ifid_wr=1 in cycle t, and IF/ID holds the word after posedge t. Throughput is one instruction per cycle with a single-cycle-ack memory.
- imem_addr is stable from the rise of imem_req until the ack.
- Reset asserted mid-request abandons the transaction. Memory must tolerate a dropped request.
- Simultaneous ack and redirect in REQ: the data is dropped, a NOP is written, and PC <= redirect_pc.

## Configuration
- FETCH_PERF_CNT_EN defined: adds outputs fetch_count[15:0] and bubble_count[15:0], both cleared by rst and saturating at 16'hFFFF.
  - fetch_count increments on every real instruction delivered.
  - bubble_count increments on every NOP written (wait bubbles and flush bubbles).
- FETCH_PERF_CNT_EN undefined: neither the ports nor the counters exist, and the rest of the behaviour is identical.

## Test plan
- Reset with RESET_PC = 16'h0010 and memory acking every cycle: fetch three words, 0x1A5B, 0x3C8E, 0xA123.
  - Delivered pc_out values 0x10, 0x11, 0x12.
  - Word 0x1A5B (R class): opcode 1, rd 5, rs1 1, rs2 3.
  - Word 0x3C8E (I class): mode 1, rd 4, rs1 4, I_imm 14.
  - Word 0xA123 (J class): jmp_offset 0x123.
- Ack delayed 3 cycles: two bubbles (ifid_wr=1, opcode 0, pc_out 0) precede the instruction; imem_addr is constant throughout.
- stall held high for 4 cycles with an ack in the first of them:
  - ifid_wr = 0 while stalled; imem_req drops after the ack.
  - The held word is delivered on the cycle stall falls, with its original PC; the next request goes to PC+1.
- redirect_valid with redirect_pc = 0x0040 while an un-acked request to 0x0012 is outstanding:
  - The NOP flush is written; the 0x0012 data is discarded on its ack.
  - The next request is addressed to 0x0040.
- PC at 0xFFFF, acked: the next imem_addr is 0x0000. Asserting rst mid-request drops imem_req immediately and restarts at RESET_PC.
- With FETCH_PERF_CNT_EN defined: 5 instructions plus 2 bubbles give fetch_count = 5 and bubble_count = 2; force fetch_count to 0xFFFF, deliver one more instruction, and check it stays at 0xFFFF.
